// File: rtl/rr_input_arbiter_pkg.sv
// rtl/rr_input_arbiter_pkg.sv - shared state encoding and ctrl constants for rr_input_arbiter
package rr_input_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PKT  = 2'd2
  } state_t;

  localparam logic [7:0] IOQ_HDR_CTRL = 8'hFF;
  localparam int         CTRL_BODY    = 0;

  // Register ring widths used by the surrounding UDP pipeline
  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_input_arbiter_if.sv
// rtl/rr_input_arbiter_if.sv - per-queue input streams and merged output stream bundle
interface rr_input_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 8
);

  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
  logic [NUM_QUEUES-1:0]            in_wr;
  logic [NUM_QUEUES-1:0]            in_rdy;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_wr;
  logic                             out_rdy;

  // master is the arbiter side, slave is the upstream/downstream environment
  modport master (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );

  modport slave (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );

endinterface

// File: rtl/rr_input_arbiter_rr_pick.sv
// rtl/rr_input_arbiter_rr_pick.sv - rotate-and-priority-encode: first non-empty queue from rr_ptr
module rr_pick #(
  parameter int NUM_QUEUES = 8,
  parameter int PTR_W      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic [NUM_QUEUES-1:0] empty,
  input  logic [PTR_W-1:0]      rr_ptr,
  output logic                  found,
  output logic [PTR_W-1:0]      idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = rr_ptr;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_QUEUES) begin
        j = j - NUM_QUEUES;
      end
      if (!found && !empty[PTR_W'(j)]) begin
        found = 1'b1;
        idx   = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/small_fifo.sv
// rtl/small_fifo.sv - shallow show-ahead FIFO; writes into a full FIFO are dropped
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty,
  input  logic             reset,
  input  logic             clk
);

  localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_CNT   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign empty       = (depth == '0);
  assign nearly_full = (depth >= NF_CNT);
  assign dout        = mem[rd_ptr];
  assign do_rd       = rd_en && !empty;
  // A concurrent read frees a slot, so a write into a full FIFO is kept only then
  assign do_wr       = wr_en && ((depth != FULL_CNT) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + (MAX_DEPTH_BITS + 1)'(1);
        2'b01:   depth <= depth - (MAX_DEPTH_BITS + 1)'(1);
        default: depth <= depth;
      endcase
    end
  end

endmodule

// File: rtl/rr_input_arbiter.sv
// rtl/rr_input_arbiter.sv - packet-granular round-robin merge of NUM_QUEUES input streams
module rr_input_arbiter
  import rr_input_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_QUEUES        = 8,
  parameter int FIFO_DEPTH_BITS   = 2,
  parameter int STAGE_NUM         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  rr_input_arbiter_if.master             bus,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);

  localparam int FW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int PTR_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  logic [NUM_QUEUES-1:0] empty;
  logic [NUM_QUEUES-1:0] nearly_full;
  logic [NUM_QUEUES-1:0] fifo_rd;
  logic [FW-1:0]         fifo_dout [NUM_QUEUES];

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] cur;
  logic [PTR_W-1:0] cur_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic             found;
  logic [PTR_W-1:0] pick_idx;
  logic             rd_en;
  logic [FW-1:0]    rd_word;
  logic [CTRL_WIDTH-1:0] rd_ctrl;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_fifo
    small_fifo #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .din         ({bus.in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .wr_en       (bus.in_wr[i]),
      .rd_en       (fifo_rd[i]),
      .dout        (fifo_dout[i]),
      .nearly_full (nearly_full[i]),
      .empty       (empty[i]),
      .reset       (reset),
      .clk         (clk)
    );
  end

  assign bus.in_rdy = ~nearly_full;

  rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .PTR_W      (PTR_W)
  ) u_pick (
    .empty  (empty),
    .rr_ptr (rr_ptr),
    .found  (found),
    .idx    (pick_idx)
  );

  assign rd_word = fifo_dout[cur];
  assign rd_ctrl = rd_word[FW-1 -: CTRL_WIDTH];
  assign rd_en   = bus.out_rdy && !empty[cur] && (state != IDLE);

  always_comb begin
    fifo_rd      = '0;
    fifo_rd[cur] = rd_en;
  end

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    rr_ptr_nxt = rr_ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          cur_nxt   = pick_idx;
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (rd_en && (rd_ctrl == CTRL_WIDTH'(CTRL_BODY))) begin
          state_nxt = PKT;
        end
      end
      PKT: begin
        // First non-zero ctrl after the body closes the packet and moves the grant on
        if (rd_en && (rd_ctrl != CTRL_WIDTH'(CTRL_BODY))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (int'(cur) == NUM_QUEUES - 1) ? '0 : cur + PTR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cur    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      cur    <= cur_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_wr      <= 1'b0;
      bus.out_data    <= '0;
      bus.out_ctrl    <= '0;
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      bus.out_wr <= rd_en;
      if (rd_en) begin
        bus.out_data <= rd_word[DATA_WIDTH-1:0];
        bus.out_ctrl <= rd_ctrl;
      end
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end

endmodule

// File: doc/rr_input_arbiter.md
Name: rr_input_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_QUEUES receive streams (MAC rx queues and CPU DMA queues) into the single 64-bit data/ctrl stream.
- Sits directly upstream of the output-port lookup stage.
- Buffers each input in a small FIFO and forwards whole packets: module headers, Ethernet words, last word. Packets are never interleaved.
- Passes the UDP register ring through with one-cycle delay.

Parameters:
- DATA_WIDTH, 64, datapath word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width; also the byte-mask width on the last word.
- UDP_REG_SRC_WIDTH, 2, register source tag width.
- NUM_QUEUES, 8, number of input streams.
- FIFO_DEPTH_BITS, 2, log2 depth of each input FIFO.
- STAGE_NUM, 2, pipeline stage number; informational only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_data  in  NUM_QUEUES*DATA_WIDTH  input words; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  input ctrl; queue i occupies bits [i*CTRL_WIDTH +: CTRL_WIDTH]
- in_wr  in  NUM_QUEUES  per-queue write strobe
- in_rdy  out  NUM_QUEUES  per-queue ready, equal to !nearly_full of that FIFO
- out_data  out  DATA_WIDTH  merged word, registered
- out_ctrl  out  CTRL_WIDTH  merged ctrl, registered
- out_wr  out  1  merged write strobe, registered
- out_rdy  in  1  downstream ready
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  register ring inputs
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  register address
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  register data
- reg_src_in  in  UDP_REG_SRC_WIDTH  register source tag
- reg_*_out  out  same widths as the matching reg_*_in  registered copies of the ring inputs

Behaviour:
- Reset: out_wr=0, out_data=0, out_ctrl=0, all reg_*_out=0, state=IDLE, rr_ptr=0, all FIFOs flushed. in_rdy is 1 from the first cycle after reset.
- Word classes: ctrl!=0 before any ctrl==0 word is a module header; ctrl==0 is a packet body word; the first ctrl!=0 word after a body word is end-of-packet (EOP). Header count per packet is arbitrary, minimum 1.
- Input writes: FIFO i is written when in_wr[i]=1.
- Write into a full FIFO: the word is discarded and the FIFO is not corrupted. This is an upstream protocol violation; the arbiter takes no other action.
- FSM states: IDLE, HDR, PKT.
- IDLE: cur = first non-empty queue scanning rr_ptr, rr_ptr+1, ... modulo NUM_QUEUES. If one is found, latch cur and go to HDR. No read in this cycle. If none is found, stay in IDLE.
- rd_en = out_rdy && !empty[cur] && state!=IDLE. Only FIFO cur is read.
- HDR: a read word with ctrl==0 moves the FSM to PKT.
- PKT: a read word with ctrl!=0 is EOP. On EOP: rr_ptr = (cur+1) mod NUM_QUEUES and state goes to IDLE.
- Output timing: out_wr <= rd_en, with the read word placed on out_data/out_ctrl in the same edge. Latency is 1 clk from read to output.
- Packet gap: one bubble cycle between consecutive packets, spent in IDLE.
- out_rdy low: no read that cycle; out_wr=0 next cycle; out_data/out_ctrl hold their previous value.
- FIFO cur empty mid-packet: stall in the current state; no output and no change of grant.
- Simultaneous write and read on the same FIFO are both honoured.
- A queue that becomes non-empty while IDLE is scanning is eligible in that same cycle.
- Reset mid-packet: the partial packet is lost, FIFOs are flushed, state returns to IDLE and rr_ptr to 0. No residual out_wr after reset.
- Register ring: every reg_*_out <= reg_*_in each clk. No registers are decoded.

Decomposition:
- Shared package: state encodings (IDLE=0, HDR=1, PKT=2), IOQ header ctrl constant 8'hFF, and a CTRL_BODY=0 constant.
- Reuse existing small_fifo, instantiated NUM_QUEUES times with width CTRL_WIDTH+DATA_WIDTH and depth FIFO_DEPTH_BITS.
- One new sub-module, rr_pick: combinational rotate-and-priority-encode. Inputs are the empty vector and rr_ptr; outputs are found and idx.

Test Plan:
- Single queue: queue 3 gets header 0xFF/0x0003_0000_0004_0040, body words ctrl=0 x4, EOP ctrl=0x80. Output shows all 6 words in order, each out_wr one clk after its read, and rr_ptr=4 afterwards.
- Fairness: queues 0, 1 and 5 each preloaded with two 3-word packets, out_rdy=1. Output packet order is 0, 1, 5, 0, 1, 5, with no interleaving and one bubble between packets.
- Backpressure: toggle out_rdy 1/0 every cycle during a 10-word packet. Exactly 10 out_wr pulses, data intact, out_wr never high in the cycle after out_rdy was low.
- Mid-packet starvation: queue 2 stops after 2 body words for 5 clks while queue 6 holds a full packet. No queue-6 word appears until queue 2's EOP completes.
- Full FIFO: write 4 words to queue 7 with out_rdy=0. in_rdy[7] drops at nearly_full; with the current header-first packet this is after 3 words.
- Reset at word 3 of a 6-word packet: out_wr=0 from the next clk, in_rdy all 1, and a fresh packet on queue 0 is forwarded cleanly.
